mode_status_reporter: RTL

- UART status transmitter: the return path for the mode/timer command channel.
- Watches the current scent mode and timer selection, encodes them with the same byte codes the command receiver accepts, and serialises a 4-byte status packet on a TX line toward the Bluetooth module / PC.
- Sits beside the mode controller and consumes its `btn_LR_out` / `btn_UD_out` outputs, so the app always reflects button-driven changes.

---
 rtl/scent_pkg.sv | 50 +++++
 rtl/uart_tx_byte.sv | 58 +++++
 rtl/mode_status_reporter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/scent_pkg.sv
// Shared byte codes, packet layout helpers and FSM encoding for the scent
// mode/timer command channel (used by both the receiver and the status reporter).
package scent_pkg;

  localparam logic [7:0] PKT_HEADER   = 8'hAA;
  localparam logic [7:0] MODE_CITRUS  = 8'h01;
  localparam logic [7:0] MODE_COTTON  = 8'h02;
  localparam logic [7:0] MODE_WOODY   = 8'h03;
  localparam logic [7:0] TIMER_30     = 8'h1E;
  localparam logic [7:0] TIMER_60     = 8'h3C;
  localparam logic [7:0] TIMER_120    = 8'h78;
  localparam logic [7:0] CODE_NONE    = 8'h00;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef struct packed {
    logic [1:0] mode;
    logic [1:0] timer;
  } sel_t;

  function automatic logic [7:0] mode_code(input logic [1:0] m);
    logic [7:0] c;
    case (m)
      2'd0:    c = MODE_COTTON;
      2'd1:    c = MODE_WOODY;
      2'd2:    c = MODE_CITRUS;
      default: c = CODE_NONE;
    endcase
    return c;
  endfunction

  function automatic logic [7:0] timer_code(input logic [1:0] t);
    logic [7:0] c;
    case (t)
      2'd0:    c = TIMER_30;
      2'd1:    c = TIMER_60;
      2'd2:    c = TIMER_120;
      default: c = CODE_NONE;
    endcase
    return c;
  endfunction

  function automatic logic [7:0] pkt_checksum(input logic [7:0] m, input logic [7:0] t);
    return PKT_HEADER ^ m ^ t;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser: start bit, eight data bits LSB first, stop bit, each
// held BIT_CYC cycles; done pulses for one cycle once the stop bit has ended.
module uart_tx_byte #(
  parameter int BIT_CYC = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done,
  output logic       busy
);

  localparam int CW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;

  logic [CW-1:0] cyc_r;
  logic [3:0]    bit_r;
  logic [7:0]    data_r;

  // Frame sequencer: bit_r is the index of the bit currently on the line (0 = start)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx     <= 1'b1;
      done   <= 1'b0;
      busy   <= 1'b0;
      cyc_r  <= '0;
      bit_r  <= 4'd0;
      data_r <= 8'h00;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          tx     <= 1'b0;
          busy   <= 1'b1;
          data_r <= data;
          cyc_r  <= '0;
          bit_r  <= 4'd0;
        end else begin
          tx <= 1'b1;
        end
      end else if (cyc_r == CW'(BIT_CYC - 1)) begin
        cyc_r <= '0;
        if (bit_r == 4'd9) begin
          busy <= 1'b0;
          done <= 1'b1;
          tx   <= 1'b1;
        end else begin
          bit_r <= bit_r + 4'd1;
          tx    <= (bit_r == 4'd8) ? 1'b1 : data_r[bit_r[2:0]];
        end
      end else begin
        cyc_r <= cyc_r + CW'(1);
      end
    end
  end

endmodule

// File: rtl/mode_status_reporter.sv
// Status return path: sends AA/mode/timer/checksum packets over UART when the
// selection changes or a request arrives. Optional periodic packets: STATUS_HEARTBEAT_EN.
module mode_status_reporter
  import scent_pkg::*;
#(
  parameter int CLK_HZ           = 1_000_000,
  parameter int BAUD             = 9600,
  parameter int HEARTBEAT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode_sel,
  input  logic [1:0] timer_sel,
  input  logic       status_req,
  output logic       tx,
  output logic       busy,
  output logic       pkt_done
);

  localparam int BIT_CYC = CLK_HZ / BAUD;

  sel_t       in_q_r, last_sent_r, snap_r;
  logic       req_q_r, req_pend_r;
  logic [1:0] state_r, state_s;
  logic [1:0] idx_r, idx_s;
  logic       busy_r, pkt_done_r;
  logic       trig_s, hb_fire_s, start_s;
  logic [7:0] byte_s;
  logic       ser_tx_s, ser_done_s, ser_busy_s;

  assign trig_s = (in_q_r != last_sent_r) | req_q_r | req_pend_r | hb_fire_s;

`ifdef STATUS_HEARTBEAT_EN
  localparam int HB_W = $clog2(HEARTBEAT_CYCLES + 1);
  logic [HB_W-1:0] hb_cnt_r;

  assign hb_fire_s = (hb_cnt_r == HB_W'(HEARTBEAT_CYCLES - 1));

  // Idle interval counter; held at zero whenever a packet starts or is in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hb_cnt_r <= '0;
    end else if ((state_r == ST_IDLE) && !trig_s) begin
      hb_cnt_r <= hb_cnt_r + HB_W'(1);
    end else begin
      hb_cnt_r <= '0;
    end
  end
`else
  assign hb_fire_s = 1'b0;
`endif

  // Packet byte selected by the current index from the frozen snapshot
  always_comb begin
    case (idx_r)
      2'd0:    byte_s = PKT_HEADER;
      2'd1:    byte_s = mode_code(snap_r.mode);
      2'd2:    byte_s = timer_code(snap_r.timer);
      2'd3:    byte_s = pkt_checksum(mode_code(snap_r.mode), timer_code(snap_r.timer));
      default: byte_s = PKT_HEADER;
    endcase
  end

  // Packet sequencing FSM next-state logic
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    start_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (trig_s) begin
          state_s = ST_SEND;
          idx_s   = 2'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (!ser_busy_s) begin
          start_s = 1'b1;
          state_s = ST_WAIT;
        end else begin
          state_s = ST_SEND;
        end
      end
      ST_WAIT: begin
        if (ser_done_s) begin
          if (idx_r == 2'd3) begin
            state_s = ST_DONE;
          end else begin
            idx_s   = idx_r + 2'd1;
            state_s = ST_SEND;
          end
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, input sampling and request bookkeeping; busy/pkt_done registered from next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      idx_r       <= 2'd0;
      in_q_r      <= '0;
      last_sent_r <= '0;
      snap_r      <= '0;
      req_q_r     <= 1'b0;
      req_pend_r  <= 1'b0;
      busy_r      <= 1'b0;
      pkt_done_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      idx_r      <= idx_s;
      in_q_r     <= {mode_sel, timer_sel};
      req_q_r    <= status_req;
      busy_r     <= (state_s != ST_IDLE);
      pkt_done_r <= (state_s == ST_DONE);
      if ((state_r == ST_IDLE) && trig_s) begin
        snap_r      <= in_q_r;
        last_sent_r <= in_q_r;
        req_pend_r  <= 1'b0;
      end else if (req_q_r && (state_r != ST_IDLE)) begin
        req_pend_r <= 1'b1;
      end else begin
        req_pend_r <= req_pend_r;
      end
    end
  end

  assign tx       = ser_tx_s;
  assign busy     = busy_r;
  assign pkt_done = pkt_done_r;

  uart_tx_byte #(.BIT_CYC(BIT_CYC)) u_ser (
    .clk   (clk),
    .reset (reset),
    .start (start_s),
    .data  (byte_s),
    .tx    (ser_tx_s),
    .done  (ser_done_s),
    .busy  (ser_busy_s)
  );

endmodule
